// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and constants for the program-counter sequencer.
//   state_t         - instruction-cycle state (IDLE, FETCH, EXEC, HALT)
//   FLAG_V..FLAG_N  - bit positions inside the 4-bit architectural flag register
package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam int FLAGS_W = 4;
  localparam int FLAG_V  = 0;  // overflow
  localparam int FLAG_C  = 1;  // carry
  localparam int FLAG_Z  = 2;  // zero
  localparam int FLAG_N  = 3;  // negative

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch and execute handshakes between the sequencer, the
// instruction memory and the decoder/datapath.
//   fetch_req/fetch_addr/fetch_ack  - instruction fetch handshake
//   exec_start/exec_done            - datapath start pulse / completion
//   flags_we/flags_in               - flag write from the datapath
//   branch_*/branch_target          - decoded branch condition and target
//   halt                            - decoded halt instruction
// master: the sequencer. slave: memory + decoder/datapath side.
interface pc_sequencer_if #(
  parameter int ADDR_W = 10
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ack;
  logic              exec_start;
  logic              exec_done;
  logic              flags_we;
  logic [3:0]        flags_in;
  logic              branch_always;
  logic              branch_overflow;
  logic              branch_carry;
  logic              branch_zero;
  logic              branch_negative;
  logic [ADDR_W-1:0] branch_target;
  logic              halt;

  modport master (
    output fetch_req, fetch_addr, exec_start,
    input  fetch_ack, exec_done, flags_we, flags_in,
           branch_always, branch_overflow, branch_carry, branch_zero,
           branch_negative, branch_target, halt
  );

  modport slave (
    input  fetch_req, fetch_addr, exec_start,
    output fetch_ack, exec_done, flags_we, flags_in,
           branch_always, branch_overflow, branch_carry, branch_zero,
           branch_negative, branch_target, halt
  );
endinterface

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: combinational branch resolution.
//   i_flags            - current (pre-update) flag register
//   i_branch_always    - unconditional branch
//   i_branch_overflow  - branch if overflow flag set
//   i_branch_carry     - branch if carry flag set
//   i_branch_zero      - branch if zero flag set
//   i_branch_negative  - branch if negative flag set
//   o_take             - branch is taken
module branch_cond_eval
  import pc_seq_pkg::*;
(
  input  logic [FLAGS_W-1:0] i_flags,
  input  logic               i_branch_always,
  input  logic               i_branch_overflow,
  input  logic               i_branch_carry,
  input  logic               i_branch_zero,
  input  logic               i_branch_negative,
  output logic               o_take
);

  assign o_take = i_branch_always
                | (i_branch_overflow & i_flags[FLAG_V])
                | (i_branch_carry    & i_flags[FLAG_C])
                | (i_branch_zero     & i_flags[FLAG_Z])
                | (i_branch_negative & i_flags[FLAG_N]);

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and instruction-cycle controller.
// Each instruction goes FETCH (req/ack with instruction memory) then EXEC
// (start/done with the datapath). On exec_done the flag register is updated,
// conditional branches are resolved against the flags as they were before
// that update, and the PC moves to the branch target or PC+1 (wrapping).
// A halt instruction parks the sequencer in HALT until reset.
//
// Ports:
//   clk, rst      - clock (rising edge), asynchronous active-high reset
//   bus           - pc_sequencer_if.master (fetch/exec handshakes, decode)
//   pc            - current program counter
//   flags         - architectural flags {N, Z, C, V}
//   branch_taken  - one-cycle pulse after a taken branch commits
//   halted        - high in HALT
//   stat_branches - (PC_SEQ_BRANCH_STATS_EN only) branch instructions seen
//   stat_taken    - (PC_SEQ_BRANCH_STATS_EN only) branches taken
//
// Optional feature: define PC_SEQ_BRANCH_STATS_EN to add the saturating
// branch statistics counters (width CNT_W).
module pc_sequencer #(
  parameter int                ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
`ifdef PC_SEQ_BRANCH_STATS_EN
  ,
  parameter int                CNT_W    = 16
`endif
) (
  input  logic               clk,
  input  logic               rst,
  pc_sequencer_if.master     bus,
  output logic [ADDR_W-1:0]  pc,
  output logic [3:0]         flags,
  output logic               branch_taken,
  output logic               halted
`ifdef PC_SEQ_BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0]   stat_branches,
  output logic [CNT_W-1:0]   stat_taken
`endif
);
  import pc_seq_pkg::*;

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [FLAGS_W-1:0]  r_flags;
  logic                r_exec_start;
  logic                r_branch_taken;
  logic                w_take;
  logic                w_commit;

  // An instruction retires on the exec_done cycle of EXEC; done seen in any
  // other state (including HALT) is ignored.
  assign w_commit = (r_state == EXEC) && bus.exec_done;

  branch_cond_eval u_branch_cond_eval (
    .i_flags           (r_flags),
    .i_branch_always   (bus.branch_always),
    .i_branch_overflow (bus.branch_overflow),
    .i_branch_carry    (bus.branch_carry),
    .i_branch_zero     (bus.branch_zero),
    .i_branch_negative (bus.branch_negative),
    .o_take            (w_take)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_next_state unassigned
    // (which would infer a latch).
    w_next_state = r_state;
    case (r_state)
      IDLE:    w_next_state = FETCH;
      FETCH:   if (bus.fetch_ack) w_next_state = EXEC;
      EXEC:    if (bus.exec_done) w_next_state = bus.halt ? HALT : FETCH;
      HALT:    w_next_state = HALT;
      default: w_next_state = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    bus.fetch_req  = (r_state == FETCH);
    bus.fetch_addr = r_pc;
    bus.exec_start = r_exec_start;
    pc             = r_pc;
    flags          = r_flags;
    branch_taken   = r_branch_taken;
    halted         = (r_state == HALT);
  end

  // PC, flags and the registered pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc           <= RESET_PC;
      r_flags        <= '0;
      r_exec_start   <= 1'b0;
      r_branch_taken <= 1'b0;
    end else begin
      // The accepted ack moves the FSM to EXEC, so this marks its first cycle.
      r_exec_start   <= (r_state == FETCH) && bus.fetch_ack;
      // Halt outranks any branch bits decoded alongside it.
      r_branch_taken <= w_commit && !bus.halt && w_take;
      if (w_commit) begin
        if (bus.flags_we) begin
          r_flags <= bus.flags_in;
        end
        if (!bus.halt) begin
          r_pc <= w_take ? bus.branch_target : r_pc + 1'b1;
        end
      end
    end
  end

`ifdef PC_SEQ_BRANCH_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             w_any_branch;
  logic [CNT_W-1:0] r_stat_branches;
  logic [CNT_W-1:0] r_stat_taken;

  assign w_any_branch = bus.branch_always | bus.branch_overflow | bus.branch_carry
                      | bus.branch_zero   | bus.branch_negative;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_branches <= '0;
      r_stat_taken    <= '0;
    end else if (w_commit && !bus.halt) begin
      if (w_any_branch && (r_stat_branches != CNT_MAX)) begin
        r_stat_branches <= r_stat_branches + 1'b1;
      end
      if (w_take && (r_stat_taken != CNT_MAX)) begin
        r_stat_taken <= r_stat_taken + 1'b1;
      end
    end
  end

  assign stat_branches = r_stat_branches;
  assign stat_taken    = r_stat_taken;
`endif

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter and instruction-cycle controller for the small CPU core.
- Fetch side: sequences each instruction through FETCH (memory req/ack handshake) and EXEC (datapath start/done handshake).
- Flags: owns the architectural flag register.
- Branches: resolves conditional branches against that register and selects the next PC (target or PC+1).
- Placement: between instruction memory, decoder and ALU datapath.

Parameters:
- ADDR_W, 10, PC / fetch address width in bits.
- RESET_PC, 0, PC value loaded on reset.
- CNT_W, 16, width of statistics counters (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_req  out  1  instruction fetch request; high throughout FETCH.
- fetch_addr  out  ADDR_W  fetch address; equals pc.
- fetch_ack  in  1  memory has returned the instruction at fetch_addr.
- exec_start  out  1  one-cycle pulse on the first EXEC cycle.
- exec_done  in  1  datapath finished; decode/flag inputs below are valid this cycle.
- flags_we  in  1  write flags_in into the flag register (qualified by exec_done).
- flags_in  in  4  new flags: [0] overflow, [1] carry, [2] zero, [3] negative.
- branch_always  in  1  unconditional branch (qualified by exec_done).
- branch_overflow  in  1  branch if flag[0].
- branch_carry  in  1  branch if flag[1].
- branch_zero  in  1  branch if flag[2].
- branch_negative  in  1  branch if flag[3].
- branch_target  in  ADDR_W  destination address when the branch is taken.
- halt  in  1  halt instruction (qualified by exec_done).
- pc  out  ADDR_W  current program counter.
- flags  out  4  flag register.
- branch_taken  out  1  one-cycle registered pulse after a taken branch commits.
- halted  out  1  high in HALT.

Behaviour:
- Reset: clk single clock; rst asynchronous, active-high. On reset:
  - state=IDLE, pc=RESET_PC, flags=0.
  - fetch_req=0, exec_start=0, branch_taken=0, halted=0.
  - Reset mid-FETCH/EXEC aborts immediately; the pending ack/done is ignored.
- States: IDLE, FETCH, EXEC, HALT. State is registered; fetch_req=(state==FETCH); halted=(state==HALT).
- IDLE: next clock -> FETCH.
- FETCH:
  - fetch_ack=1 -> EXEC; exec_start=1 in the next cycle.
  - Ack is accepted in the first FETCH cycle.
  - Otherwise stay in FETCH, holding pc.
- EXEC:
  - exec_done is accepted in any EXEC cycle, including the one where exec_start is high.
  - Minimum throughput: 2 cycles per instruction.
  - On exec_done, take = branch_always | (branch_overflow&flags[0]) | (branch_carry&flags[1]) | (branch_zero&flags[2]) | (branch_negative&flags[3]).
  - Conditions use the pre-update flag register, i.e. flags set by earlier instructions.
  - On the same edge:
    - flags <= flags_in if flags_we.
    - pc <= take ? branch_target : pc+1. The increment wraps modulo 2^ADDR_W, so max address wraps to 0.
    - branch_taken <= take.
    - state -> FETCH.
  - halt=1 with exec_done: halt has priority over branch. pc is not updated, flags_we is still honoured, state -> HALT.
- HALT: terminal until rst. Every input is ignored.
- Inputs other than fetch_ack/exec_done are don't-care outside their qualifying cycle.

Optional Feature:
- Macro: PC_SEQ_BRANCH_STATS_EN.
- With the macro defined, two extra outputs exist:
  - stat_branches [CNT_W], incremented on every exec_done with any branch_* bit set.
  - stat_taken [CNT_W], incremented on each taken branch.
  - Both saturate at all-ones, reset to 0, and do not count when halt=1.
- Without the macro: no ports, no counters.

Decomposition:
- Package pc_seq_pkg holds:
  - state enum (IDLE, FETCH, EXEC, HALT);
  - flag index constants FLAG_V=0, FLAG_C=1, FLAG_Z=2, FLAG_N=3.
- Sub-module branch_cond_eval: combinational take computation from the flags and the five branch_* inputs.
- Everything else is in pc_sequencer.

Test Plan:
1. Reset, ADDR_W=10, RESET_PC=0x010, ack and done immediate -> fetch_addr sequence 0x010, 0x011, 0x012; fetch_req high every other cycle; exec_start pulses alternate.
2. ALU instruction with flags_we=1, flags_in=0b0100, then branch_zero=1, target=0x200 -> pc=0x200, branch_taken pulses once. Repeat with flags_in=0b0000 -> pc+1, no pulse.
3. Same-cycle flags_we=1 (flags_in=0b0010) with branch_carry=1 while flags=0 -> not taken, because the pre-update flags are used; flags becomes 0b0010 afterwards.
4. pc=0x3FF, non-branch instruction -> pc=0x000. fetch_ack delayed 3 cycles -> fetch_req held high 4 cycles, pc stable.
5. halt=1 with branch_always=1 -> HALT, halted=1, pc unchanged, no further fetch_req. Later assert rst during EXEC -> immediate IDLE, pc=RESET_PC.
6. With PC_SEQ_BRANCH_STATS_EN: 3 branches, 2 taken -> stat_branches=3, stat_taken=2. With CNT_W=2 and 5 branches -> stat_branches saturates at 3.
